// File: rtl/hello_msg_sequencer.sv
// ---------------------------------------------------------------------------
// hello_msg_sequencer
//
// Steps through the fixed message "HELLO WORLD" and presents one character
// per timer interval to a character display driver over a valid/ready
// handshake. It enables the one-second tick timer while it waits for the next
// character slot. It consumes the timer's `last` / `pre_last` pulses as `tick`
// and `pre_tick`.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous, active-low reset
//   start       in   begin a message pass (sampled only in IDLE)
//   stop        in   synchronous abort back to IDLE from any state
//   tick        in   one-cycle pulse from the timer `last`
//   pre_tick    in   one-cycle pulse from the timer `pre_last`
//   timer_en    out  timer enable; the timer reloads its maximum while low
//   char_data   out  current character
//   char_valid  out  char_data/char_idx are valid
//   char_ready  in   display driver accepts char_data
//   char_idx    out  message index of char_data
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse at the end of a non-looping pass
//
// All outputs come straight from registers. The next values of every output
// are computed together with the next state, so each output register reflects
// the state it belongs to in the same cycle.
// ---------------------------------------------------------------------------
module hello_msg_sequencer #(
  parameter int pMSG_LEN = 11,
  parameter int pLOOP    = 0,
  parameter int pCHAR_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        tick,
  input  logic                        pre_tick,
  output logic                        timer_en,
  output logic [pCHAR_W-1:0]          char_data,
  output logic                        char_valid,
  input  logic                        char_ready,
  output logic [$clog2(pMSG_LEN)-1:0] char_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int IDX_W = $clog2(pMSG_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pMSG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    PRESENT   = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t               state_r, state_nx;
  logic [pCHAR_W-1:0]   char_data_r, char_data_nx;
  logic [IDX_W-1:0]     char_idx_r, char_idx_nx;
  logic                 char_valid_r, char_valid_nx;
  logic                 timer_en_r, timer_en_nx;
  logic                 busy_r, busy_nx;
  logic                 done_r, done_nx;
  logic                 transfer;

  // Message ROM: "HELLO WORLD" in ASCII, indexed by character position.
  function automatic logic [pCHAR_W-1:0] rom_char(input logic [IDX_W-1:0] idx);
    logic [pCHAR_W-1:0] ch;
    case (idx)
      IDX_W'(0):  ch = pCHAR_W'(8'h48); // H
      IDX_W'(1):  ch = pCHAR_W'(8'h45); // E
      IDX_W'(2):  ch = pCHAR_W'(8'h4C); // L
      IDX_W'(3):  ch = pCHAR_W'(8'h4C); // L
      IDX_W'(4):  ch = pCHAR_W'(8'h4F); // O
      IDX_W'(5):  ch = pCHAR_W'(8'h20); // space
      IDX_W'(6):  ch = pCHAR_W'(8'h57); // W
      IDX_W'(7):  ch = pCHAR_W'(8'h4F); // O
      IDX_W'(8):  ch = pCHAR_W'(8'h52); // R
      IDX_W'(9):  ch = pCHAR_W'(8'h4C); // L
      IDX_W'(10): ch = pCHAR_W'(8'h44); // D
      default:    ch = {pCHAR_W{1'b0}};
    endcase
    return ch;
  endfunction

  assign transfer = char_valid_r & char_ready;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      char_data_r  <= {pCHAR_W{1'b0}};
      char_idx_r   <= {IDX_W{1'b0}};
      char_valid_r <= 1'b0;
      timer_en_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nx;
      char_data_r  <= char_data_nx;
      char_idx_r   <= char_idx_nx;
      char_valid_r <= char_valid_nx;
      timer_en_r   <= timer_en_nx;
      busy_r       <= busy_nx;
      done_r       <= done_nx;
    end
  end

  // Next-state and next-output logic; stop overrides everything else.
  always_comb begin
    state_nx      = state_r;
    char_data_nx  = char_data_r;
    char_idx_nx   = char_idx_r;
    char_valid_nx = char_valid_r;
    timer_en_nx   = timer_en_r;
    busy_nx       = busy_r;
    done_nx       = 1'b0;

    if (stop) begin
      state_nx      = IDLE;
      char_idx_nx   = {IDX_W{1'b0}};
      char_valid_nx = 1'b0;
      timer_en_nx   = 1'b0;
      busy_nx       = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_nx      = WAIT_TICK;
            char_idx_nx   = {IDX_W{1'b0}};
            char_valid_nx = 1'b0;
            timer_en_nx   = 1'b1;
            busy_nx       = 1'b1;
          end else begin
            char_valid_nx = 1'b0;
            timer_en_nx   = 1'b0;
            busy_nx       = 1'b0;
          end
        end

        WAIT_TICK: begin
          // pre_tick prefetches; tick loads again so a timer with max 0
          // (which never raises pre_tick) still yields the right character.
          if (tick) begin
            state_nx      = PRESENT;
            char_data_nx  = rom_char(char_idx_r);
            char_valid_nx = 1'b1;
            timer_en_nx   = 1'b0;
          end else if (pre_tick) begin
            char_data_nx  = rom_char(char_idx_r);
            timer_en_nx   = 1'b1;
          end else begin
            char_valid_nx = 1'b0;
            timer_en_nx   = 1'b1;
          end
        end

        PRESENT: begin
          // Timer stays in reload during a stall, so the next interval
          // starts only after the character has been accepted.
          if (transfer) begin
            if (char_idx_r != LAST_IDX) begin
              state_nx      = WAIT_TICK;
              char_idx_nx   = char_idx_r + IDX_W'(1);
              char_valid_nx = 1'b0;
              timer_en_nx   = 1'b1;
            end else if (pLOOP != 0) begin
              state_nx      = WAIT_TICK;
              char_idx_nx   = {IDX_W{1'b0}};
              char_valid_nx = 1'b0;
              timer_en_nx   = 1'b1;
            end else begin
              state_nx      = DONE;
              char_valid_nx = 1'b0;
              timer_en_nx   = 1'b0;
              done_nx       = 1'b1;
            end
          end else begin
            char_valid_nx = 1'b1;
            timer_en_nx   = 1'b0;
          end
        end

        DONE: begin
          state_nx      = IDLE;
          char_valid_nx = 1'b0;
          timer_en_nx   = 1'b0;
          busy_nx       = 1'b0;
        end

        default: begin
          state_nx      = IDLE;
          char_idx_nx   = {IDX_W{1'b0}};
          char_valid_nx = 1'b0;
          timer_en_nx   = 1'b0;
          busy_nx       = 1'b0;
        end
      endcase
    end
  end

  assign timer_en   = timer_en_r;
  assign char_data  = char_data_r;
  assign char_valid = char_valid_r;
  assign char_idx   = char_idx_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_hello_msg_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for hello_msg_sequencer.
// dut0: pLOOP = 0, dut1: pLOOP = 1. Each has a small tick-timer model with
// max = 3 (last on the 4th enabled cycle, pre_last on the 3rd). dut0 can
// also be driven with direct tick/pre_tick from a vector table.
// ---------------------------------------------------------------------------
module tb_hello_msg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  logic [7:0] msg [11] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20,
                           8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};

  // Shared / dut0 stimulus
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic ready = 1'b0;
  logic tick_drv = 1'b0;
  logic pre_drv = 1'b0;
  logic use_timer = 1'b0;
  logic start_l = 1'b0;

  // dut0 outputs
  logic       ten0, valid0, busy0, done0;
  logic [7:0] data0;
  logic [3:0] idx0;
  // dut1 outputs
  logic       ten1, valid1, busy1, done1;
  logic [7:0] data1;
  logic [3:0] idx1;

  // Timer models
  logic [1:0] cnt0 = 2'd3;
  logic [1:0] cnt1 = 2'd3;
  logic t0_last, t0_pre, t1_last, t1_pre, tick0, pre0;

  always @(posedge clk) begin
    if (ten0 !== 1'b1 || cnt0 == 2'd0) cnt0 <= 2'd3;
    else                               cnt0 <= cnt0 - 2'd1;
  end
  always @(posedge clk) begin
    if (ten1 !== 1'b1 || cnt1 == 2'd0) cnt1 <= 2'd3;
    else                               cnt1 <= cnt1 - 2'd1;
  end
  assign t0_last = (ten0 === 1'b1) && (cnt0 == 2'd0);
  assign t0_pre  = (ten0 === 1'b1) && (cnt0 == 2'd1);
  assign t1_last = (ten1 === 1'b1) && (cnt1 == 2'd0);
  assign t1_pre  = (ten1 === 1'b1) && (cnt1 == 2'd1);
  assign tick0   = use_timer ? t0_last : tick_drv;
  assign pre0    = use_timer ? t0_pre  : pre_drv;

  logic done1_seen = 1'b0;
  always @(posedge clk) begin
    if (done1 === 1'b1) done1_seen <= 1'b1;
  end

  hello_msg_sequencer #(.pMSG_LEN(11), .pLOOP(0), .pCHAR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .tick(tick0), .pre_tick(pre0), .timer_en(ten0),
    .char_data(data0), .char_valid(valid0), .char_ready(ready),
    .char_idx(idx0), .busy(busy0), .done(done0)
  );

  hello_msg_sequencer #(.pMSG_LEN(11), .pLOOP(1), .pCHAR_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_l), .stop(1'b0),
    .tick(t1_last), .pre_tick(t1_pre), .timer_en(ten1),
    .char_data(data1), .char_valid(valid1), .char_ready(1'b1),
    .char_idx(idx1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid0(input int exp_n);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (valid0 !== 1'b1 && n < 40);
    chk("latency0", n, exp_n);
  endtask

  task automatic wait_valid1(input int exp_n);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (valid1 !== 1'b1 && n < 40);
    chk("latency1", n, exp_n);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       rst_n, start, stop, tick, pre, ready;
    logic       valid;
    logic [7:0] data;
    logic [3:0] idx;
    logic       ten, busy, done;
  } vec_t;

  vec_t vt [14];

  initial begin
    // rst start stop tick pre rdy | valid data idx ten busy done
    vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,8'h00,4'd0,1'b0,1'b0,1'b0}; // reset
    vt[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,8'h00,4'd0,1'b0,1'b0,1'b0}; // start+stop
    vt[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,8'h00,4'd0,1'b1,1'b1,1'b0}; // start
    vt[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,8'h48,4'd0,1'b0,1'b1,1'b0}; // tick
    vt[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,8'h48,4'd0,1'b0,1'b1,1'b0}; // stall, tick ignored
    vt[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,8'h00,4'd1,1'b1,1'b1,1'b0}; // transfer
    vt[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1,8'h45,4'd1,1'b0,1'b1,1'b0}; // tick
    vt[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,8'h00,4'd2,1'b1,1'b1,1'b0}; // transfer
    vt[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1,8'h4C,4'd2,1'b0,1'b1,1'b0}; // tick
    vt[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,8'h00,4'd3,1'b1,1'b1,1'b0}; // transfer
    vt[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,8'h00,4'd3,1'b1,1'b1,1'b0}; // pre_tick only
    vt[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1,8'h4C,4'd3,1'b0,1'b1,1'b0}; // tick
    vt[12] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,8'h00,4'd0,1'b0,1'b0,1'b0}; // stop wins
    vt[13] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,8'h00,4'd0,1'b0,1'b0,1'b0}; // ticks in IDLE

    // ---- Table-driven, direct tick control ----
    for (int i = 0; i < 14; i++) begin
      rst_n = vt[i].rst_n; start = vt[i].start; stop = vt[i].stop;
      tick_drv = vt[i].tick; pre_drv = vt[i].pre; ready = vt[i].ready;
      step();
      chk($sformatf("vec%0d.valid", i), 32'(valid0), 32'(vt[i].valid));
      if (vt[i].valid) chk($sformatf("vec%0d.data", i), 32'(data0), 32'(vt[i].data));
      chk($sformatf("vec%0d.idx", i),   32'(idx0),   32'(vt[i].idx));
      chk($sformatf("vec%0d.ten", i),   32'(ten0),   32'(vt[i].ten));
      chk($sformatf("vec%0d.busy", i),  32'(busy0),  32'(vt[i].busy));
      chk($sformatf("vec%0d.done", i),  32'(done0),  32'(vt[i].done));
    end
    start = 1'b0; stop = 1'b0; tick_drv = 1'b0; pre_drv = 1'b0;
    use_timer = 1'b1;
    step();

    // ---- Full non-looping pass, ready tied high ----
    ready = 1'b1; start = 1'b1; step(); start = 1'b0;
    chk("pass.start_ten", 32'(ten0), 32'd1);
    chk("pass.start_busy", 32'(busy0), 32'd1);
    chk("pass.start_idx", 32'(idx0), 32'd0);
    for (int k = 0; k < 11; k++) begin
      wait_valid0(k == 0 ? 4 : 5);
      chk($sformatf("pass.data%0d", k), 32'(data0), 32'(msg[k]));
      chk($sformatf("pass.idx%0d", k),  32'(idx0),  32'(k));
      chk($sformatf("pass.ten%0d", k),  32'(ten0),  32'd0);
      chk($sformatf("pass.done%0d", k), 32'(done0), 32'd0);
    end
    step();
    chk("pass.done_pulse", 32'(done0), 32'd1);
    chk("pass.done_busy", 32'(busy0), 32'd1);
    chk("pass.done_valid", 32'(valid0), 32'd0);
    step();
    chk("pass.done_clear", 32'(done0), 32'd0);
    chk("pass.busy_fall", 32'(busy0), 32'd0);

    // ---- Ready stall at index 2 ----
    start = 1'b1; step(); start = 1'b0;
    wait_valid0(4);
    wait_valid0(5);
    wait_valid0(5);
    chk("stall.idx", 32'(idx0), 32'd2);
    ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("stall.valid", 32'(valid0), 32'd1);
      chk("stall.data", 32'(data0), 32'h4C);
      chk("stall.ten", 32'(ten0), 32'd0);
    end
    ready = 1'b1;
    wait_valid0(5);
    chk("stall.next_data", 32'(data0), 32'h4C);
    chk("stall.next_idx", 32'(idx0), 32'd3);
    wait_valid0(5);
    chk("stall.idx4", 32'(idx0), 32'd4);

    // ---- stop coincident with tick at index 5 ----
    repeat (4) step();
    chk("stop.tick_cycle", 32'(t0_last), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop.valid", 32'(valid0), 32'd0);
    chk("stop.ten", 32'(ten0), 32'd0);
    chk("stop.idx", 32'(idx0), 32'd0);
    chk("stop.busy", 32'(busy0), 32'd0);
    chk("stop.done", 32'(done0), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stop.idle_done", 32'(done0), 32'd0);
      chk("stop.idle_busy", 32'(busy0), 32'd0);
    end
    start = 1'b1; step(); start = 1'b0;
    wait_valid0(4);
    chk("restart.data", 32'(data0), 32'h48);
    chk("restart.idx", 32'(idx0), 32'd0);
    stop = 1'b1; step(); stop = 1'b0;

    // ---- start held while busy, then reset in PRESENT at index 7 ----
    start = 1'b1; step();
    for (int k = 0; k < 8; k++) begin
      wait_valid0(k == 0 ? 4 : 5);
      chk($sformatf("rst.data%0d", k), 32'(data0), 32'(msg[k]));
      chk($sformatf("rst.idx%0d", k),  32'(idx0),  32'(k));
    end
    start = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst.valid", 32'(valid0), 32'd0);
    chk("rst.data", 32'(data0), 32'd0);
    chk("rst.idx", 32'(idx0), 32'd0);
    chk("rst.ten", 32'(ten0), 32'd0);
    chk("rst.busy", 32'(busy0), 32'd0);
    chk("rst.done", 32'(done0), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("rst.restart_busy", 32'(busy0), 32'd1);
    chk("rst.restart_ten", 32'(ten0), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;

    // ---- Looping instance: wraps from index 10 to 0, never done ----
    start_l = 1'b1; step(); start_l = 1'b0;
    for (int k = 0; k < 13; k++) begin
      wait_valid1(k == 0 ? 4 : 5);
      chk($sformatf("loop.data%0d", k), 32'(data1), 32'(msg[k % 11]));
      chk($sformatf("loop.idx%0d", k),  32'(idx1),  32'(k % 11));
      chk($sformatf("loop.busy%0d", k), 32'(busy1), 32'd1);
    end
    step();
    chk("loop.no_done", 32'(done1_seen), 32'd0);
    chk("loop.busy_end", 32'(busy1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
